// File: rtl/sky130_ef_ip__rdac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sky130_ef_ip__rdac_pkg
// Brief    : Shared state and mode encodings for the ramping resistor DAC.
// Revision : 1.0 - initial release
// ============================================================================
package sky130_ef_ip__rdac_pkg;

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_SETTLE = 2'd1,
        S_IDLE   = 2'd2,
        S_RAMP   = 2'd3
    } rdac_state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RAMP   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sky130_ef_ip__rdac3v_nbit.sv
`default_nettype none
// ============================================================================
// Module   : sky130_ef_ip__rdac3v_nbit
// Brief    : Behavioural N-bit resistor-string DAC core (real-valued output).
// Revision : 1.0 - initial release
// ============================================================================
module sky130_ef_ip__rdac3v_nbit #(
    parameter int WIDTH      = 8,
    parameter int FUNCTIONAL = 1
) (
`ifdef USE_POWER_PINS
    inout  wire               vdd,
    inout  wire               vss,
`endif
    input  logic              ena,
    input  logic [WIDTH-1:0]  code,
    input  real               Vlow,
    input  real               Vhigh,
    output real               out
);

    localparam real C_FULL_SCALE = real'((64'd1 << WIDTH) - 64'd1);

    generate
        if (FUNCTIONAL != 0) begin : g_model
            always_comb begin
                out = 0.0;
                if (ena) begin
                    out = Vlow + real'(code) * (Vhigh - Vlow) / C_FULL_SCALE;
                end
            end
        end else begin : g_stub
            // Structural views leave the analog node to the netlist.
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sky130_ef_ip__rdac3v_ramp.sv
`default_nettype none
// ============================================================================
// Module   : sky130_ef_ip__rdac3v_ramp
// Brief    : Handshaked DAC controller with settle window and slew-limited ramp.
// Revision : 1.0 - initial release
// ============================================================================
module sky130_ef_ip__rdac3v_ramp
    import sky130_ef_ip__rdac_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DIV_W      = 8,
    parameter int SETTLE     = 4,
    parameter int FUNCTIONAL = 1
) (
`ifdef USE_POWER_PINS
    inout  wire               vdd,
    inout  wire               vss,
    inout  wire               dvdd,
    inout  wire               dvss,
`endif
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              mode,
    input  logic [WIDTH-1:0]  tgt,
    input  logic              tgt_valid,
    output logic              tgt_ready,
    input  logic [WIDTH-1:0]  step,
    input  logic [DIV_W-1:0]  ramp_div,
    input  real               Vlow,
    input  real               Vhigh,
    output logic [WIDTH-1:0]  code,
    output logic              busy,
    output logic              done,
    output real               out
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    rdac_state_e      r_state, w_state_d;
    logic [WIDTH-1:0] r_code, w_code_d;
    logic [WIDTH-1:0] r_target, w_target_d;
    logic [DIV_W-1:0] r_presc, w_presc_d;
    logic [SW-1:0]    r_settle, w_settle_d;
    logic             r_done, w_done_d;

    logic             w_up;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_step_eff;
    logic [WIDTH:0]   w_delta;
    logic [WIDTH-1:0] w_next_code;

    // Distance is kept one bit wider so the clamp never wraps at full scale.
    always_comb begin
        w_up        = (r_target > r_code);
        w_diff      = w_up ? ({1'b0, r_target} - {1'b0, r_code})
                           : ({1'b0, r_code} - {1'b0, r_target});
        w_step_eff  = (step == '0) ? WIDTH'(1) : step;
        w_delta     = ({1'b0, w_step_eff} < w_diff) ? {1'b0, w_step_eff} : w_diff;
        w_next_code = w_up ? (r_code + w_delta[WIDTH-1:0])
                           : (r_code - w_delta[WIDTH-1:0]);
    end

    always_comb begin
        w_state_d  = r_state;
        w_code_d   = r_code;
        w_target_d = r_target;
        w_presc_d  = r_presc;
        w_settle_d = r_settle;
        w_done_d   = 1'b0;
        if (!ena) begin
            w_state_d = S_OFF;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_state_d  = S_SETTLE;
                    w_settle_d = '0;
                end
                S_SETTLE: begin
                    if (r_settle == SW'(SETTLE - 1)) begin
                        w_state_d = S_IDLE;
                    end else begin
                        w_settle_d = r_settle + SW'(1);
                    end
                end
                S_IDLE: begin
                    if (tgt_valid) begin
                        if (mode == MODE_RAMP && tgt != r_code) begin
                            w_target_d = tgt;
                            w_presc_d  = '0;
                            w_state_d  = S_RAMP;
                        end else begin
                            w_code_d = tgt;
                            w_done_d = 1'b1;
                        end
                    end
                end
                S_RAMP: begin
                    if (r_presc == ramp_div) begin
                        w_presc_d = '0;
                        w_code_d  = w_next_code;
                        if (w_next_code == r_target) begin
                            w_state_d = S_IDLE;
                            w_done_d  = 1'b1;
                        end
                    end else begin
                        w_presc_d = r_presc + DIV_W'(1);
                    end
                end
                default: w_state_d = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_OFF;
            r_code   <= '0;
            r_target <= '0;
            r_presc  <= '0;
            r_settle <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_code   <= w_code_d;
            r_target <= w_target_d;
            r_presc  <= w_presc_d;
            r_settle <= w_settle_d;
            r_done   <= w_done_d;
        end
    end

    assign tgt_ready = ena && (r_state == S_IDLE);
    assign busy      = (r_state == S_SETTLE) || (r_state == S_RAMP);
    assign done      = r_done;
    assign code      = r_code;

    sky130_ef_ip__rdac3v_nbit #(
        .WIDTH      (WIDTH),
        .FUNCTIONAL (FUNCTIONAL)
    ) u_core (
`ifdef USE_POWER_PINS
        .vdd   (vdd),
        .vss   (vss),
`endif
        .ena   (ena && (r_state != S_OFF)),
        .code  (r_code),
        .Vlow  (Vlow),
        .Vhigh (Vhigh),
        .out   (out)
    );

endmodule
`default_nettype wire

// File: tb/tb_sky130_ef_ip__rdac3v_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_sky130_ef_ip__rdac3v_ramp
// Brief    : Directed self-checking bench with a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sky130_ef_ip__rdac3v_ramp;

    localparam int W = 8;
    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic        mode = 1'b0;
    logic        tgt_valid = 1'b0;
    logic [7:0]  tgt = '0;
    logic [7:0]  step = '0;
    logic [7:0]  ramp_div = '0;
    real         vlow = 0.0;
    real         vhigh = 3.3;
    logic        tgt_ready, busy, done;
    logic [7:0]  code;
    real         out;

    logic        ena12 = 1'b0;
    logic        tgt_valid12 = 1'b0;
    logic [11:0] tgt12 = '0;
    logic [11:0] step12 = '0;
    logic [7:0]  div12 = '0;
    logic        ready12, busy12, done12;
    logic [11:0] code12;
    real         out12;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sky130_ef_ip__rdac3v_ramp #(.WIDTH(W), .DIV_W(8), .SETTLE(S), .FUNCTIONAL(1)) dut (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode), .tgt(tgt), .tgt_valid(tgt_valid),
        .tgt_ready(tgt_ready), .step(step), .ramp_div(ramp_div), .Vlow(vlow), .Vhigh(vhigh),
        .code(code), .busy(busy), .done(done), .out(out)
    );

    sky130_ef_ip__rdac3v_ramp #(.WIDTH(12), .DIV_W(8), .SETTLE(S), .FUNCTIONAL(1)) dut12 (
        .clk(clk), .rst(rst), .ena(ena12), .mode(1'b0), .tgt(tgt12), .tgt_valid(tgt_valid12),
        .tgt_ready(ready12), .step(step12), .ramp_div(div12), .Vlow(vlow), .Vhigh(vhigh),
        .code(code12), .busy(busy12), .done(done12), .out(out12)
    );

    task automatic chk_i(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_r(input string name, input real act, input real exp);
        real d;
        vectors++;
        d = act - exp;
        if (d < 0.0) d = -d;
        if (d > 1.0e-5) begin
            miscompares++;
            $display("FAIL %s: got %f, expected %f (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks what the spec says should be visible after each edge.
    bit m_on = 1'b0;
    bit m_ramp = 1'b0;
    bit m_done = 1'b0;
    int m_settle = 0;
    int m_code = 0;
    int m_tgt = 0;
    int m_elapsed = 0;
    int m_s, m_d;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_on = 1'b0; m_ramp = 1'b0; m_done = 1'b0;
            m_settle = 0; m_code = 0; m_tgt = 0; m_elapsed = 0;
        end else begin
            m_done = 1'b0;
            if (!ena) begin
                m_on = 1'b0; m_ramp = 1'b0; m_settle = 0;
            end else if (!m_on) begin
                m_on = 1'b1; m_settle = S;
            end else if (m_settle > 0) begin
                m_settle--;
            end else if (m_ramp) begin
                if (m_elapsed == int'(ramp_div)) begin
                    m_s = (step == 0) ? 1 : int'(step);
                    m_d = (m_tgt > m_code) ? m_tgt - m_code : m_code - m_tgt;
                    if (m_s > m_d) m_s = m_d;
                    m_code = (m_tgt > m_code) ? m_code + m_s : m_code - m_s;
                    m_elapsed = 0;
                    if (m_code == m_tgt) begin
                        m_ramp = 1'b0; m_done = 1'b1;
                    end
                end else begin
                    m_elapsed = (m_elapsed + 1) % 256;
                end
            end else if (tgt_valid) begin
                if (mode && int'(tgt) != m_code) begin
                    m_tgt = int'(tgt); m_ramp = 1'b1; m_elapsed = 0;
                end else begin
                    m_code = int'(tgt); m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk_i("model code", code, m_code);
            chk_i("model busy", busy, m_on && (m_settle > 0 || m_ramp));
            chk_i("model ready", tgt_ready, ena && m_on && m_settle == 0 && !m_ramp);
            chk_i("model done", done, m_done);
            chk_r("model out", out, (ena && m_on) ? vlow + m_code * (vhigh - vlow) / 255.0 : 0.0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int v);
        mode = 1'b0; tgt = 8'(v); tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0;
        tick();
    endtask

    int up_exp[12] = '{0, 0, 30, 30, 30, 60, 60, 60, 90, 90, 90, 100};
    int dn_exp[3]  = '{4, 3, 2};

    initial begin
        #1 rst = 1'b1;
        repeat (2) tick();
        chk_i("reset code", code, 0);
        chk_i("reset busy", busy, 0);
        chk_i("reset done", done, 0);
        chk_i("reset ready", tgt_ready, 0);
        chk_r("reset out", out, 0.0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Settle window
        vlow = 0.2; ena = 1'b1;
        tick();
        for (int i = 0; i < S; i++) begin
            chk_i("settle ready", tgt_ready, 0);
            chk_i("settle busy", busy, 1);
            tick();
        end
        chk_i("post-settle ready", tgt_ready, 1);
        chk_i("post-settle code", code, 0);
        chk_r("post-settle out", out, 0.2);
        vlow = 0.0;

        // Back-to-back direct accepts
        mode = 1'b0; tgt = 8'd200; tgt_valid = 1'b1;
        tick();
        tgt = 8'd10;
        chk_i("direct code 200", code, 200);
        chk_i("direct done", done, 1);
        chk_r("direct out", out, 2.588235);
        tick();
        tgt_valid = 1'b0;
        chk_i("direct code 10", code, 10);
        tick();
        chk_i("direct done clear", done, 0);

        // Ramp up
        load(0);
        mode = 1'b1; tgt = 8'd100; step = 8'd30; ramp_div = 8'd2; tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk_i("ramp up code", code, up_exp[k-1]);
            if (k < 12) chk_i("ramp up ready", tgt_ready, 0);
        end
        chk_i("ramp up done", done, 1);
        tick();
        chk_i("ramp up done clear", done, 0);

        // Ramp down with step 0
        load(5);
        mode = 1'b1; tgt = 8'd2; step = 8'd0; ramp_div = 8'd0; tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_i("ramp down code", code, dn_exp[k]);
        end
        chk_i("ramp down done", done, 1);
        tick();

        // Abort by dropping ena
        load(0);
        mode = 1'b1; tgt = 8'd255; step = 8'd1; ramp_div = 8'd0; tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0;
        repeat (40) tick();
        chk_i("abort code", code, 40);
        ena = 1'b0;
        #1;
        chk_r("abort out", out, 0.0);
        tick();
        chk_i("abort hold code", code, 40);
        chk_i("abort busy", busy, 0);
        chk_i("abort done", done, 0);
        tick();
        ena = 1'b1;
        tick();
        for (int i = 0; i < S; i++) begin
            chk_i("resettle busy", busy, 1);
            chk_i("resettle code", code, 40);
            tick();
        end
        chk_i("resettle ready", tgt_ready, 1);

        // Asynchronous reset in the middle of a ramp
        mode = 1'b1; tgt = 8'd200; tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0;
        repeat (2) tick();
        #1 rst = 1'b1;
        #1;
        chk_i("async rst code", code, 0);
        chk_i("async rst busy", busy, 0);
        chk_i("async rst done", done, 0);
        chk_r("async rst out", out, 0.0);
        tick();
        rst = 1'b0;

        // 12-bit full-scale
        ena12 = 1'b1;
        repeat (S + 2) tick();
        chk_i("w12 ready", ready12, 1);
        tgt12 = 12'd4095; tgt_valid12 = 1'b1;
        tick();
        tgt_valid12 = 1'b0;
        chk_i("w12 code", code12, 4095);
        chk_i("w12 done", done12, 1);
        chk_r("w12 out", out12, 3.3);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sky130_ef_ip__rdac3v_ramp.md
Name: sky130_ef_ip__rdac3v_ramp

Overview:
Parametrised successor to the 8-bit 3.3V resistor DAC: a clocked controller plus behavioural N-bit DAC core. It accepts target codes over a valid/ready handshake. It applies each code either directly or as a slew-limited ramp with programmable step and rate, and enforces a settle interval after enable. It sits between the digital (1.8V) register block and the analog output pin.

Parameters:
WIDTH, 8, DAC code width; full scale is 2^WIDTH-1.
DIV_W, 8, width of the ramp prescaler input.
SETTLE, 4, clock cycles after enable before the first target is accepted (SETTLE>=1).
FUNCTIONAL, 1, 1 = real-valued output model active; 0 = output left undriven.

Ports:
clk  input  1  block clock (dvdd domain).
rst  input  1  asynchronous, active-high reset.
vdd, vss, dvdd, dvss  inout  1  power pins, present only under USE_POWER_PINS.
ena  input  1  enable, active high.
mode  input  1  0 = direct update, 1 = ramp; sampled at handshake accept.
tgt  input  WIDTH  target code.
tgt_valid  input  1  target offered.
tgt_ready  output  1  target can be accepted this cycle.
step  input  WIDTH  ramp increment per tick; 0 is treated as 1.
ramp_div  input  DIV_W  one ramp tick every ramp_div+1 cycles.
Vlow, Vhigh  input  real  reference rails.
code  output  WIDTH  code currently applied to the DAC.
busy  output  1  high in SETTLE or RAMP.
done  output  1  one-cycle pulse when a target has been reached.
out  output  real  analog output.

Behaviour:
- Reset (async, rst=1): state=OFF, code=0, internal target=0, prescaler=0, settle counter=0, done=0, tgt_ready=0, busy=0, out=0.0.
- States:
  - OFF: entered on reset or whenever ena=0. tgt_ready=0. code holds its last value.
  - SETTLE: entered on ena=1 while in OFF; settle counter loaded with 0. Move to IDLE after exactly SETTLE cycles in SETTLE. tgt_ready=0.
  - IDLE: tgt_ready=1. Accept occurs on the edge with tgt_valid=1 and tgt_ready=1.
  - RAMP: tgt_ready=0. Prescaler counts 0..ramp_div. On the wrap edge (prescaler==ramp_div), code moves toward the target by min(max(step,1), |target-code|). No overshoot or wraparound; the difference is computed in WIDTH+1 bits. On the edge where code becomes equal to target, go to IDLE and pulse done for the following cycle.
- Direct accept (mode=0): code<=tgt on the accept edge. done=1 for the next cycle. Stay in IDLE, so back-to-back accepts are possible every cycle.
- Ramp accept (mode=1):
  - If tgt==code: behave as a direct accept (done pulse, stay IDLE).
  - Otherwise: latch target, clear prescaler, enter RAMP. The first code change occurs ramp_div+1 cycles after accept.
- ramp_div and step are sampled live during RAMP. Changing them mid-ramp takes effect at the next tick.
- ena falling in any state: next state is OFF. An in-flight ramp is abandoned with no done pulse; code keeps its partial value. Re-enabling always passes through SETTLE.
- ena low and tgt_valid high in the same cycle: no accept.
- out is combinational from the registered code:
  - out = Vlow + code*(Vhigh-Vlow)/(2^WIDTH-1) when ena=1 and state!=OFF.
  - out = 0.0 otherwise.
  - Vlow and Vhigh changes are reflected immediately.
- done is registered and is never high for two consecutive cycles from a single accept.
- busy = (state==SETTLE)||(state==RAMP).

Decomposition:
- Shared package (sky130_ef_ip__rdac_pkg): state encoding constants OFF=2'd0, SETTLE=2'd1, IDLE=2'd2, RAMP=2'd3, and the mode constants MODE_DIRECT=0, MODE_RAMP=1.
- One sub-module, sky130_ef_ip__rdac3v_nbit: parametrised WIDTH behavioural DAC core (ena, code, Vlow, Vhigh -> out, under FUNCTIONAL). It generalises the existing fixed 8-bit core.
- The top level holds the FSM, settle counter, prescaler and step arithmetic.

Test Plan:
- Reset then ena=1, WIDTH=8, SETTLE=4: tgt_ready stays 0 for exactly 4 cycles, then goes 1; busy=1 during those 4 cycles; code=0, out=Vlow.
- Direct: mode=0, tgt=8'd200 accepted, Vlow=0.0, Vhigh=3.3 -> code=200 after the accept edge, out=2.588235, done pulses 1 cycle; a second accept of tgt=8'd10 on the next cycle gives code=10.
- Ramp up: code=0, mode=1, tgt=100, step=30, ramp_div=2 -> code goes 30, 60, 90, 100 at 3, 6, 9, 12 cycles after accept; done pulses once after 100; tgt_ready=0 throughout.
- Ramp down with step=0: code=5, tgt=2, ramp_div=0 -> code 4, 3, 2 on successive cycles; done after reaching 2.
- Abort: ramp 0->255, step=1, ramp_div=0; drop ena at code=40 -> state OFF, out=0.0, code holds 40, no done pulse. Re-enabling gives a SETTLE of 4 cycles with code still 40.
- Async reset mid-ramp: assert rst between clock edges -> code=0, busy=0, done=0 immediately, without waiting for a clock edge. A parameter sweep with WIDTH=12 and a full-scale direct load of 4095 gives out=Vhigh.
